// File: rtl/difftest_arch_event_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ difftest ArchEvent sources through a
// DEPTH-entry FIFO into the single per-hart ArchEvent sink (simulation-only block).
module difftest_arch_event_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DEPTH   = 4,
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_interrupt,
    input  logic [32*NUM_REQ-1:0]   req_exception,
    input  logic [64*NUM_REQ-1:0]   req_exceptionPC,
    input  logic [32*NUM_REQ-1:0]   req_exceptionInst,
    input  logic [8*NUM_REQ-1:0]    req_coreid,
    input  logic                    out_ready,
    output logic                    out_enable,
    output logic [31:0]             out_interrupt,
    output logic [31:0]             out_exception,
    output logic [63:0]             out_exceptionPC,
    output logic [31:0]             out_exceptionInst,
    output logic [7:0]              out_coreid,
    output logic [PTR_W:0]          occupancy
);

    localparam int unsigned RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] interrupt;
        logic [31:0] exception;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [7:0]  coreid;
    } event_t;

    event_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [RR_W-1:0]    rr_ptr;

    logic               space;
    logic               push;
    logic               pop;
    logic               grant_any;
    logic [RR_W-1:0]    grant_idx;
    logic [RR_W-1:0]    rr_next;
    logic [NUM_REQ-1:0] rot_valid;
    event_t             grant_event;
    event_t             head_event;

    // Pushes never borrow the same-cycle pop slot.
    assign space = (count < CNT_W'(DEPTH));
    assign pop   = (count != '0) && out_ready;
    assign push  = space && grant_any && !reset;

    // Rotate valids so bit 0 is the rr_ptr requester, then pick the lowest set bit.
    always_comb begin : arbitrate
        logic [RR_W-1:0] offset;
        logic [RR_W:0]   sum;
        grant_any = 1'b0;
        offset    = '0;
        sum       = '0;
        rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (rot_valid[i]) begin
                grant_any = 1'b1;
                offset    = RR_W'(i);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= (RR_W+1)'(NUM_REQ)) begin
            sum = sum - (RR_W+1)'(NUM_REQ);
        end
        grant_idx = sum[RR_W-1:0];
    end

    always_comb begin : ready_decode
        req_ready = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_ready[i] = push && (grant_idx == RR_W'(i));
        end
    end

    always_comb begin : grant_mux
        grant_event = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_idx == RR_W'(i)) begin
                grant_event.interrupt = req_interrupt[32*i +: 32];
                grant_event.exception = req_exception[32*i +: 32];
                grant_event.pc        = req_exceptionPC[64*i +: 64];
                grant_event.inst      = req_exceptionInst[32*i +: 32];
                grant_event.coreid    = req_coreid[8*i +: 8];
            end
        end
    end

    always_comb begin : rr_advance
        rr_next = rr_ptr;
        if (push) begin
            if (grant_idx == RR_W'(NUM_REQ - 1)) begin
                rr_next = '0;
            end else begin
                rr_next = grant_idx + RR_W'(1);
            end
        end
    end

    // Storage is deliberately not reset; count gates every read of it.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= grant_event;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_event        = (count != '0) ? mem[rd_ptr] : '0;
    assign out_enable        = pop;
    assign out_interrupt     = head_event.interrupt;
    assign out_exception     = head_event.exception;
    assign out_exceptionPC   = head_event.pc;
    assign out_exceptionInst = head_event.inst;
    assign out_coreid        = head_event.coreid;
    assign occupancy         = count;

endmodule

// File: tb/tb_difftest_arch_event_arbiter.sv
// Self-checking bench for difftest_arch_event_arbiter: directed vector table,
// hand sequences for multi-cycle corners, and randomized traffic against a queue model.
module tb_difftest_arch_event_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PTR_W   = 2;

    typedef struct packed {
        logic [31:0] intr;
        logic [31:0] exc;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [7:0]  coreid;
    } ev_t;

    typedef struct {
        logic [1:0]  valid;
        logic        ordy;
        logic [63:0] pc0;
        logic [1:0]  exp_ready;
        logic        exp_en;
        logic [2:0]  exp_occ;
        logic [63:0] exp_pc;
    } vec_t;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_interrupt = '0;
    logic [32*NUM_REQ-1:0] req_exception = '0;
    logic [64*NUM_REQ-1:0] req_exceptionPC = '0;
    logic [32*NUM_REQ-1:0] req_exceptionInst = '0;
    logic [8*NUM_REQ-1:0]  req_coreid = '0;
    logic                  out_ready = 1'b0;
    logic                  out_enable;
    logic [31:0]           out_interrupt;
    logic [31:0]           out_exception;
    logic [63:0]           out_exceptionPC;
    logic [31:0]           out_exceptionInst;
    logic [7:0]            out_coreid;
    logic [PTR_W:0]        occupancy;

    int checks = 0;
    int errors = 0;

    ev_t                src [NUM_REQ];
    logic [NUM_REQ-1:0] pend = '0;
    ev_t                q[$];
    int                 rr = 0;
    logic [NUM_REQ-1:0] exp_ready;
    logic               exp_en;
    ev_t                exp_head;
    int                 exp_g;

    difftest_arch_event_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_interrupt(req_interrupt), .req_exception(req_exception),
        .req_exceptionPC(req_exceptionPC), .req_exceptionInst(req_exceptionInst),
        .req_coreid(req_coreid), .out_ready(out_ready), .out_enable(out_enable),
        .out_interrupt(out_interrupt), .out_exception(out_exception),
        .out_exceptionPC(out_exceptionPC), .out_exceptionInst(out_exceptionInst),
        .out_coreid(out_coreid), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            assert (occupancy <= 3'(DEPTH))
            else begin
                errors++;
                $error("FAIL occupancy_bound: got %0d max %0d", occupancy, DEPTH);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [167:0] act, input logic [167:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic ev_t dut_head();
        return {out_interrupt, out_exception, out_exceptionPC, out_exceptionInst, out_coreid};
    endfunction

    task automatic drive();
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_valid[i]                 = pend[i];
            req_interrupt[32*i +: 32]    = src[i].intr;
            req_exception[32*i +: 32]    = src[i].exc;
            req_exceptionPC[64*i +: 64]  = src[i].pc;
            req_exceptionInst[32*i +: 32] = src[i].inst;
            req_coreid[8*i +: 8]         = src[i].coreid;
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #2;
    endtask

    // Entered and left 2 time units after a rising edge.
    task automatic do_reset();
        pend = '0;
        drive();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        q.delete();
        rr = 0;
        next_cycle();
    endtask

    function automatic ev_t tbl_event(input logic [63:0] pc);
        ev_t e;
        e.intr   = 32'h8000_0007;
        e.exc    = 32'h0;
        e.pc     = pc;
        e.inst   = pc[31:0] ^ 32'h13;
        e.coreid = 8'd0;
        return e;
    endfunction

    // Reference model: FIFO as a queue, round-robin as a scan from rr.
    task automatic model_eval();
        exp_ready = '0;
        exp_g     = -1;
        if (q.size() < int'(DEPTH)) begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                int idx;
                idx = (rr + k) % int'(NUM_REQ);
                if (exp_g < 0 && pend[idx]) exp_g = idx;
            end
        end
        if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
        exp_en   = (q.size() != 0) && out_ready;
        exp_head = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic model_commit();
        if (exp_en) void'(q.pop_front());
        if (exp_g >= 0) begin
            q.push_back(src[exp_g]);
            rr = (exp_g + 1) % int'(NUM_REQ);
            pend[exp_g] = 1'b0;
        end
    endtask

    function automatic ev_t rand_event(input int i);
        ev_t e;
        e.intr   = $urandom;
        e.exc    = $urandom;
        e.pc     = {$urandom, $urandom};
        e.inst   = $urandom;
        e.coreid = 8'(i);
        if ($urandom % 8 == 0) begin
            e.intr = '0;
            e.exc  = '0;
        end
        return e;
    endfunction

    vec_t tbl [16];

    initial begin
        ev_t  e;
        logic [63:0] got[$];
        int   k;
        int   cyc;
        logic granted;

        tbl[0]  = '{2'b01, 1'b1, 64'h8000_1000, 2'b01, 1'b0, 3'd0, 64'h0};
        tbl[1]  = '{2'b00, 1'b1, 64'h0,         2'b00, 1'b1, 3'd1, 64'h8000_1000};
        tbl[2]  = '{2'b00, 1'b1, 64'h0,         2'b00, 1'b0, 3'd0, 64'h0};
        tbl[3]  = '{2'b01, 1'b0, 64'h200,       2'b01, 1'b0, 3'd0, 64'h0};
        tbl[4]  = '{2'b01, 1'b0, 64'h208,       2'b01, 1'b0, 3'd1, 64'h200};
        tbl[5]  = '{2'b01, 1'b0, 64'h210,       2'b01, 1'b0, 3'd2, 64'h200};
        tbl[6]  = '{2'b01, 1'b0, 64'h218,       2'b01, 1'b0, 3'd3, 64'h200};
        tbl[7]  = '{2'b01, 1'b0, 64'h220,       2'b00, 1'b0, 3'd4, 64'h200};
        tbl[8]  = '{2'b01, 1'b0, 64'h220,       2'b00, 1'b0, 3'd4, 64'h200};
        tbl[9]  = '{2'b01, 1'b1, 64'h220,       2'b00, 1'b1, 3'd4, 64'h200};
        tbl[10] = '{2'b01, 1'b0, 64'h220,       2'b01, 1'b0, 3'd3, 64'h208};
        tbl[11] = '{2'b00, 1'b1, 64'h0,         2'b00, 1'b1, 3'd4, 64'h208};
        tbl[12] = '{2'b00, 1'b1, 64'h0,         2'b00, 1'b1, 3'd3, 64'h210};
        tbl[13] = '{2'b00, 1'b1, 64'h0,         2'b00, 1'b1, 3'd2, 64'h218};
        tbl[14] = '{2'b00, 1'b1, 64'h0,         2'b00, 1'b1, 3'd1, 64'h220};
        tbl[15] = '{2'b00, 1'b0, 64'h0,         2'b00, 1'b0, 3'd0, 64'h0};

        // Reset state with both requesters valid and the sink ready.
        src[0] = tbl_event(64'h10);
        src[1] = tbl_event(64'h20);
        pend = 2'b11;
        out_ready = 1'b1;
        drive();
        #3;
        chk("reset_ready", 168'(req_ready), 168'(0));
        chk("reset_enable", 168'(out_enable), 168'(0));
        chk("reset_occ", 168'(occupancy), 168'(0));
        chk("reset_fields", 168'(dut_head()), 168'(0));
        #4;
        reset = 1'b0;

        for (int r = 0; r < 16; r++) begin
            pend      = tbl[r].valid;
            out_ready = tbl[r].ordy;
            src[0]    = tbl_event(tbl[r].pc0);
            src[1]    = '0;
            drive();
            #1;
            chk($sformatf("tbl%0d_ready", r), 168'(req_ready), 168'(tbl[r].exp_ready));
            chk($sformatf("tbl%0d_enable", r), 168'(out_enable), 168'(tbl[r].exp_en));
            chk($sformatf("tbl%0d_occ", r), 168'(occupancy), 168'(tbl[r].exp_occ));
            chk($sformatf("tbl%0d_head", r), 168'(dut_head()),
                (tbl[r].exp_pc == 64'h0) ? 168'(0) : 168'(tbl_event(tbl[r].exp_pc)));
            next_cycle();
        end

        // Both requesters valid continuously: grants alternate 0,1,0,1.
        do_reset();
        src[0] = tbl_event(64'hA0);
        src[1] = tbl_event(64'hB0);
        src[1].coreid = 8'd1;
        pend = 2'b11;
        out_ready = 1'b1;
        drive();
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("alt%0d_ready", c), 168'(req_ready), (c % 2 == 0) ? 168'(1) : 168'(2));
            chk($sformatf("alt%0d_enable", c), 168'(out_enable), (c == 0) ? 168'(0) : 168'(1));
            chk($sformatf("alt%0d_occ", c), 168'(occupancy), (c == 0) ? 168'(0) : 168'(1));
            if (c > 0) chk($sformatf("alt%0d_coreid", c), 168'(out_coreid), 168'((c - 1) % 2));
            next_cycle();
        end

        // Wrap-around: 10 events through a 4-entry FIFO with interleaved draining.
        do_reset();
        k = 0;
        cyc = 0;
        while (got.size() < 10 && cyc < 80) begin
            pend[0] = (k < 10);
            src[0] = tbl_event(64'h100 + 64'(8 * k));
            out_ready = (cyc % 3 != 0);
            drive();
            #1;
            granted = req_ready[0];
            if (out_enable) got.push_back(out_exceptionPC);
            next_cycle();
            if (granted) k++;
            cyc++;
        end
        chk("wrap_count", 168'(got.size()), 168'(10));
        for (int j = 0; j < got.size() && j < 10; j++) begin
            chk($sformatf("wrap_pc%0d", j), 168'(got[j]), 168'(64'h100 + 64'(8 * j)));
        end
        pend = '0;
        out_ready = 1'b1;
        drive();
        #1;
        chk("wrap_drained_occ", 168'(occupancy), 168'(0));
        chk("wrap_drained_enable", 168'(out_enable), 168'(0));
        next_cycle();

        // Reset between edges with three events queued.
        do_reset();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            pend[0] = 1'b1;
            src[0] = tbl_event(64'h300 + 64'(8 * j));
            drive();
            next_cycle();
        end
        src[0] = tbl_event(64'h318);
        out_ready = 1'b1;
        drive();
        #1;
        chk("rst_pre_occ", 168'(occupancy), 168'(3));
        chk("rst_pre_enable", 168'(out_enable), 168'(1));
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_enable", 168'(out_enable), 168'(0));
        chk("rst_mid_occ", 168'(occupancy), 168'(0));
        chk("rst_mid_ready", 168'(req_ready), 168'(0));
        #1;
        reset = 1'b0;
        out_ready = 1'b0;
        src[0] = tbl_event(64'hABC);
        drive();
        #1;
        chk("rst_post_ready", 168'(req_ready), 168'(1));
        next_cycle();
        pend = '0;
        out_ready = 1'b1;
        drive();
        #1;
        chk("rst_post_enable", 168'(out_enable), 168'(1));
        chk("rst_post_head", 168'(dut_head()), 168'(tbl_event(64'hABC)));
        next_cycle();
        #1;
        chk("rst_post_empty", 168'(occupancy), 168'(0));

        // Randomized traffic against the queue model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    src[i] = rand_event(i);
                end
            end
            out_ready = ($urandom % 2 == 0);
            drive();
            #1;
            model_eval();
            chk("rnd_ready", 168'(req_ready), 168'(exp_ready));
            chk("rnd_enable", 168'(out_enable), 168'(exp_en));
            chk("rnd_occ", 168'(occupancy), 168'(q.size()));
            chk("rnd_head", 168'(dut_head()), 168'(exp_head));
            next_cycle();
            model_commit();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
